memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-stage outputs in an EX/MEM register.
- Performs the data-memory load or store, then registers the results into a MEM/WB register for the writeback stage.
- Provides stall and flush controls for the hazard unit.

Parameters:
- DATA_WIDTH, 32, data and ALU result width in bits.
- DMEM_ADDR_BITS, 8, word-address bits; memory depth = 2**DMEM_ADDR_BITS words.
- REG_ADDR_BITS, 5, register-file index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- Stall  in  1  hold EX/MEM register; insert bubble into MEM/WB
- Flush  in  1  load bubble into EX/MEM register
- RegWriteIn  in  1  register-write control from execute
- MemToRegIn  in  1  load-select control from execute
- MemWriteIn  in  1  store control from execute
- ALUResultIn  in  DATA_WIDTH  ALU result; byte address for loads/stores
- WriteDataIn  in  DATA_WIDTH  store data
- WriteRegIn  in  REG_ADDR_BITS  destination register
- RegWriteW  out  1  registered register-write control
- MemToRegW  out  1  registered load-select control
- ReadDataW  out  DATA_WIDTH  registered load data
- ALUResultW  out  DATA_WIDTH  registered ALU result
- WriteRegW  out  REG_ADDR_BITS  registered destination register

Behaviour:
- Reset:
  - Asserting rst immediately clears EX/MEM and MEM/WB: all control bits 0, all data 0.
  - All outputs read 0 while rst is high, including reset asserted mid-operation.
  - Data-memory contents are not reset.
- EX/MEM register (M-stage values: RegWriteM, MemToRegM, MemWriteM, ALUResultM, WriteDataM, WriteRegM):
  - Each posedge, priority order:
    - Flush=1: load bubble (all 0).
    - Else Stall=1: hold current contents.
    - Else: capture the *In ports.
  - Flush overrides Stall.
- Addressing:
  - Word index = ALUResultM[DMEM_ADDR_BITS+1:2].
  - Bits [1:0] are ignored (word-aligned access).
  - Bits above DMEM_ADDR_BITS+1 are ignored, so addresses alias/wrap modulo the memory size.
- Store:
  - At posedge, mem[index] <= WriteDataM when MemWriteM=1 and Stall=0.
  - A stalled store writes exactly once, on the cycle its stall is released.
- Load:
  - Read is combinational from mem[index] and captured into MEM/WB.
  - A load in the cycle after a store to the same word returns the new data.
- MEM/WB register, each posedge:
  - Stall=1: load bubble (RegWriteW=0, MemToRegW=0, data and WriteRegW = 0).
  - Else: capture RegWriteM, MemToRegM, mem[index], ALUResultM and WriteRegM.
- Latency: values presented on the *In ports at edge k appear on the *W outputs after edge k+1 (two edges), plus one edge per stalled cycle.
- Control passes through unchanged: no ALU or forwarding logic in this block.

Optional Feature:
- Macro: MEMORY_STAGE_MISALIGN_EN.
- Defined:
  - Adds output MisalignedW (1 bit, reset 0).
  - Registered high in MEM/WB when (MemWriteM | MemToRegM) and ALUResultM[1:0] != 0.
  - A misaligned store is suppressed: memory is not written.
  - A misaligned load still returns the aligned word.
  - MisalignedW is cleared by a bubble.
- Undefined:
  - No MisalignedW port.
  - Low address bits are silently ignored; misaligned stores write the aligned word.

Test Plan:
- Reset: drive RegWriteIn=1, ALUResultIn=0x1234, run 1 cycle, assert rst mid-cycle -> all outputs 0 immediately, before the next edge.
- Passthrough: RegWriteIn=1, MemToRegIn=0, ALUResultIn=0x00001234, WriteRegIn=5 -> after 2 edges RegWriteW=1, ALUResultW=0x1234, WriteRegW=5, MemToRegW=0.
- Store then load:
  - Stimulus: store 0xDEADBEEF to 0x10, then next cycle load 0x10 with WriteRegIn=8.
  - Required: 2 edges after the load, ReadDataW=0xDEADBEEF, MemToRegW=1, RegWriteW=1, WriteRegW=8.
- Stall:
  - Stimulus: store 0xA5A5A5A5 to 0x20 held by Stall for 3 cycles, with a monitor on writes to word 8.
  - Required: exactly one write to word 8; MEM/WB shows bubbles during the stall; a subsequent load of 0x20 returns 0xA5A5A5A5.
- Flush:
  - Stimulus: pre-store 0x11111111 at 0x30; present a store of 0x22222222 to 0x30 with Flush=1 at its capture edge; then load 0x30.
  - Required: ReadDataW=0x11111111.
- Wrap and misalign:
  - Stimulus: store 0xCAFEF00D at 0x400 (DMEM_ADDR_BITS=8), then load 0x000.
  - Required: ReadDataW=0xCAFEF00D.
  - With MEMORY_STAGE_MISALIGN_EN, a store to 0x402 -> MisalignedW=1 and word 0 unchanged.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX/MEM register, word-addressed data memory access and MEM/WB register
// Optional feature macro: MEMORY_STAGE_MISALIGN_EN (adds MisalignedW, suppresses misaligned stores)
module memory_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int DMEM_ADDR_BITS = 8,
  parameter int REG_ADDR_BITS  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     RegWriteIn,
  input  logic                     MemToRegIn,
  input  logic                     MemWriteIn,
  input  logic [DATA_WIDTH-1:0]    ALUResultIn,
  input  logic [DATA_WIDTH-1:0]    WriteDataIn,
  input  logic [REG_ADDR_BITS-1:0] WriteRegIn,
  output logic                     RegWriteW,
  output logic                     MemToRegW,
  output logic [DATA_WIDTH-1:0]    ReadDataW,
  output logic [DATA_WIDTH-1:0]    ALUResultW,
`ifdef MEMORY_STAGE_MISALIGN_EN
  output logic                     MisalignedW,
`endif
  output logic [REG_ADDR_BITS-1:0] WriteRegW
);

  localparam int DEPTH = 2 ** DMEM_ADDR_BITS;

  logic                      reg_write_m;
  logic                      mem_to_reg_m;
  logic                      mem_write_m;
  logic [DATA_WIDTH-1:0]     alu_result_m;
  logic [DATA_WIDTH-1:0]     write_data_m;
  logic [REG_ADDR_BITS-1:0]  write_reg_m;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [DMEM_ADDR_BITS-1:0] word_index;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      store_en;

  // Flush wins over Stall so a squashed instruction can never be held in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      write_reg_m  <= '0;
    end else if (Flush) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      write_reg_m  <= '0;
    end else if (!Stall) begin
      reg_write_m  <= RegWriteIn;
      mem_to_reg_m <= MemToRegIn;
      mem_write_m  <= MemWriteIn;
      alu_result_m <= ALUResultIn;
      write_data_m <= WriteDataIn;
      write_reg_m  <= WriteRegIn;
    end
  end

  // Byte address to word index; upper bits drop off so accesses wrap.
  assign word_index = alu_result_m[DMEM_ADDR_BITS+1:2];
  assign read_data  = mem[word_index];

`ifdef MEMORY_STAGE_MISALIGN_EN
  logic misaligned;
  assign misaligned = (mem_write_m | mem_to_reg_m) && (alu_result_m[1:0] != 2'b00);
  assign store_en   = mem_write_m & ~Stall & ~misaligned;
`else
  assign store_en   = mem_write_m & ~Stall;
`endif

  // A stalled store stays in EX/MEM and commits only on its release edge.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[word_index] <= write_data_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || Stall) begin
      RegWriteW   <= 1'b0;
      MemToRegW   <= 1'b0;
      ReadDataW   <= '0;
      ALUResultW  <= '0;
      WriteRegW   <= '0;
`ifdef MEMORY_STAGE_MISALIGN_EN
      MisalignedW <= 1'b0;
`endif
    end else begin
      RegWriteW   <= reg_write_m;
      MemToRegW   <= mem_to_reg_m;
      ReadDataW   <= read_data;
      ALUResultW  <= alu_result_m;
      WriteRegW   <= write_reg_m;
`ifdef MEMORY_STAGE_MISALIGN_EN
      MisalignedW <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a transaction-level model
module tb_memory_stage;

  localparam int AB    = 8;
  localparam int DEPTH = 2 ** AB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        rw_in = 1'b0, mtr_in = 1'b0, mw_in = 1'b0;
  logic [31:0] alu_in = '0, wd_in = '0;
  logic [4:0]  wreg_in = '0;
  logic        rw_w, mtr_w;
  logic [31:0] rd_w, alu_w;
  logic [4:0]  wreg_w;
`ifdef MEMORY_STAGE_MISALIGN_EN
  logic        mis_w;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .Stall(stall), .Flush(flush),
    .RegWriteIn(rw_in), .MemToRegIn(mtr_in), .MemWriteIn(mw_in),
    .ALUResultIn(alu_in), .WriteDataIn(wd_in), .WriteRegIn(wreg_in),
    .RegWriteW(rw_w), .MemToRegW(mtr_w), .ReadDataW(rd_w), .ALUResultW(alu_w),
`ifdef MEMORY_STAGE_MISALIGN_EN
    .MisalignedW(mis_w),
`endif
    .WriteRegW(wreg_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in the memory slot, a word array, and what writeback must show.
  typedef struct packed {
    logic        rw, mtr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wreg;
  } instr_t;

  instr_t      m_slot;
  logic [31:0] mmem [DEPTH];
  bit          known [DEPTH];
  logic        e_rw, e_mtr, e_mis;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wreg;
  bit          e_rd_known;

  always @(posedge clk or posedge rst) begin : model
    int idx;
    bit mis, suppress;
    if (rst) begin
      m_slot = '0;
      {e_rw, e_mtr, e_mis, e_rd, e_alu, e_wreg} = '0;
      e_rd_known = 1'b1;
    end else begin
      idx = int'(m_slot.alu[AB+1:2]);
      mis = (m_slot.mw || m_slot.mtr) && (m_slot.alu[1:0] != 2'b00);
`ifdef MEMORY_STAGE_MISALIGN_EN
      suppress = mis;
`else
      suppress = 1'b0;
`endif
      if (stall) begin
        {e_rw, e_mtr, e_mis, e_rd, e_alu, e_wreg} = '0;
        e_rd_known = 1'b1;
      end else begin
        e_rw = m_slot.rw;  e_mtr = m_slot.mtr;  e_alu = m_slot.alu;  e_wreg = m_slot.wreg;
        e_rd = mmem[idx];  e_rd_known = known[idx];  e_mis = mis;
      end
      if (m_slot.mw && !stall && !suppress) begin
        mmem[idx]  = m_slot.wd;
        known[idx] = 1'b1;
      end
      if (flush)       m_slot = '0;
      else if (!stall) m_slot = {rw_in, mtr_in, mw_in, alu_in, wd_in, wreg_in};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_RegWriteW", 32'(rw_w), 32'(e_rw));
      chk("cyc_MemToRegW", 32'(mtr_w), 32'(e_mtr));
      chk("cyc_ALUResultW", alu_w, e_alu);
      chk("cyc_WriteRegW", 32'(wreg_w), 32'(e_wreg));
      if (e_rd_known) chk("cyc_ReadDataW", rd_w, e_rd);
`ifdef MEMORY_STAGE_MISALIGN_EN
      chk("cyc_MisalignedW", 32'(mis_w), 32'(e_mis));
`endif
    end
  end

  task automatic drive(input logic rw, input logic mtr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wreg, input logic st, input logic fl);
    rw_in = rw; mtr_in = mtr; mw_in = mw; alu_in = alu; wd_in = wd; wreg_in = wreg;
    stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b0, 1'b1, addr, data, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] wreg);
    drive(1'b1, 1'b1, 1'b0, addr, 32'h0, wreg, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  // Reset raised between edges must clear every output before the next edge.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_RegWriteW", 32'(rw_w), 32'h0);
    chk("rst_MemToRegW", 32'(mtr_w), 32'h0);
    chk("rst_ReadDataW", rd_w, 32'h0);
    chk("rst_ALUResultW", alu_w, 32'h0);
    chk("rst_WriteRegW", 32'(wreg_w), 32'h0);
`ifdef MEMORY_STAGE_MISALIGN_EN
    chk("rst_MisalignedW", 32'(mis_w), 32'h0);
`endif
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h3C00_0000 ^ (i * 32'h0001_0203);
  endfunction

  initial begin
    int changes;
    logic [31:0] prev8;

    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b0);
    chk("pre_rst_RegWriteW", 32'(rw_w), 32'h1);
    chk("pre_rst_ALUResultW", alu_w, 32'h1234);
    reset_pulse();

    for (int i = 0; i < DEPTH; i++) store(32'(i * 4), init_word(i));
    bubble();

    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0);
    bubble();
    chk("pass_RegWriteW", 32'(rw_w), 32'h1);
    chk("pass_ALUResultW", alu_w, 32'h1234);
    chk("pass_WriteRegW", 32'(wreg_w), 32'h5);
    chk("pass_MemToRegW", 32'(mtr_w), 32'h0);

    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 5'd8);
    bubble();
    chk("stld_ReadDataW", rd_w, 32'hDEAD_BEEF);
    chk("stld_MemToRegW", 32'(mtr_w), 32'h1);
    chk("stld_RegWriteW", 32'(rw_w), 32'h1);
    chk("stld_WriteRegW", 32'(wreg_w), 32'h8);

    store(32'h20, 32'hA5A5_A5A5);
    changes = 0;
    prev8 = dut.mem[8];
    for (int k = 0; k < 3; k++) begin
      drive(1'($urandom), 1'($urandom), 1'b1, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0);
      chk("stall_bubble_ALUResultW", alu_w, 32'h0);
      chk("stall_bubble_RegWriteW", 32'(rw_w), 32'h0);
      if (dut.mem[8] !== prev8) changes++;
      prev8 = dut.mem[8];
    end
    load(32'h20, 5'd9);
    if (dut.mem[8] !== prev8) changes++;
    prev8 = dut.mem[8];
    bubble();
    if (dut.mem[8] !== prev8) changes++;
    chk("stall_word8_writes", 32'(changes), 32'h1);
    chk("stall_ReadDataW", rd_w, 32'hA5A5_A5A5);

    store(32'h30, 32'h1111_1111);
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h2222_2222, 5'd0, 1'b0, 1'b1);
    load(32'h30, 5'd3);
    bubble();
    chk("flush_ReadDataW", rd_w, 32'h1111_1111);

    store(32'h400, 32'hCAFE_F00D);
    load(32'h000, 5'd4);
    bubble();
    chk("wrap_ReadDataW", rd_w, 32'hCAFE_F00D);

`ifdef MEMORY_STAGE_MISALIGN_EN
    store(32'h402, 32'h1234_5678);
    load(32'h000, 5'd4);
    chk("misalign_flag", 32'(mis_w), 32'h1);
    bubble();
    chk("misalign_word0_kept", rd_w, 32'hCAFE_F00D);
    chk("misalign_flag_clear", 32'(mis_w), 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
      if (i == 1500) reset_pulse();
    end
    bubble();
    bubble();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
